// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, PCSrc encodings, fetch FSM states and instruction field positions
package cpu_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd1;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_BEQ   = 6'd32;
  localparam logic [5:0] OP_BNE   = 6'd33;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_HOLD   = 2'd3;
  localparam int OP_LSB  = 26;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_LSB = 0;
  localparam int JT_W    = 26;
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_EXEC} fetch_state_t;
endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: PC write enable and next-PC select
//   pc, jump_target          current PC and ir[25:0]
//   pc_write, pc_write_cond  unconditional / branch write requests
//   beq, zero                branch sense and ALU zero flag
//   pc_src                   0 alu_result, 1 alu_out, 2 jump, 3 hold
//   pc_we, pc_next           write enable and selected next PC
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [JT_W-1:0]   jump_target,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic              beq,
  input  logic              zero,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] alu_out,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_next
);
  assign pc_we = pc_write | (pc_write_cond & (beq ? zero : ~zero));
  // jump keeps the upper PC bits, so it stays within the current 2^26-word region
  assign pc_next = pc_src == PCSRC_ALU    ? alu_result :
                   pc_src == PCSRC_ALUOUT ? alu_out :
                   pc_src == PCSRC_JUMP   ? {pc[ADDR_W-1:JT_W], jump_target} : pc;
endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC and instruction register owner with req/ack instruction fetch
//   clock, reset (async, active-high), run: start/continue fetching
//   imem_req/imem_addr/imem_ack/imem_rdata: instruction memory handshake
//   instr_done, PCWrite, PCWriteCond, BEQ, PCSrc: control FSM commands
//   alu_result, alu_out, zero: datapath PC sources and flag
//   pc, ir, OPcode, rs, rt, rd, imm16, ir_valid: fetch results
//   fetch_err: sticky fetch timeout flag
//   Optional macro FETCH_TIMEOUT_EN: abort a fetch after TIMEOUT_CYC cycles without ack
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              instr_done,
  input  logic              PCWrite,
  input  logic              PCWriteCond,
  input  logic              BEQ,
  input  logic [1:0]        PCSrc,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [ADDR_W-1:0] alu_out,
  input  logic              zero,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic [5:0]        OPcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm16,
  output logic              ir_valid,
  output logic              fetch_err
);
  fetch_state_t state;
  logic pc_we;
  logic timeout;
  logic [ADDR_W-1:0] pc_next;
  pc_next_mux #(.ADDR_W(ADDR_W)) u_mux (
    .pc(pc),
    .jump_target(ir[JT_W-1:0]),
    .pc_write(PCWrite),
    .pc_write_cond(PCWriteCond),
    .beq(BEQ),
    .zero(zero),
    .pc_src(PCSrc),
    .alu_result(alu_result),
    .alu_out(alu_out),
    .pc_we(pc_we),
    .pc_next(pc_next)
  );
  // PC never changes while a fetch is outstanding, so the address is stable
  assign imem_addr = pc;
  assign OPcode = ir[OP_LSB +: 6];
  assign rs = ir[RS_LSB +: 5];
  assign rt = ir[RT_LSB +: 5];
  assign rd = ir[RD_LSB +: 5];
  assign imm16 = ir[IMM_LSB +: 16];
`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt;
  logic fetching;
  assign fetching = (state == ST_REQ) || (state == ST_WAIT);
  // fires on the TIMEOUT_CYC-th consecutive fetch cycle without ack
  assign timeout = fetching && !imem_ack && (cnt == CW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt <= '0;
    else cnt <= (fetching && !imem_ack && !timeout) ? cnt + 1'b1 : '0;
  end
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      pc <= RESET_PC;
      ir <= '0;
      imem_req <= 1'b0;
      ir_valid <= 1'b0;
      fetch_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (run && !fetch_err) begin
          state <= ST_REQ;
          imem_req <= 1'b1;
        end
        ST_REQ, ST_WAIT: if (imem_ack) begin
          ir <= imem_rdata;
          state <= ST_EXEC;
          imem_req <= 1'b0;
          ir_valid <= 1'b1;
        end else if (timeout) begin
          fetch_err <= 1'b1;
          imem_req <= 1'b0;
          state <= ST_IDLE;
        end else begin
          state <= ST_WAIT;
        end
        ST_EXEC: begin
          if (pc_we) pc <= pc_next;
          if (instr_done) begin
            state <= run ? ST_REQ : ST_IDLE;
            imem_req <= run;
            ir_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit
module tb_fetch_pc_unit;
  logic clock = 0, reset = 1, run = 1, imem_ack = 0, instr_done = 0;
  logic PCWrite = 0, PCWriteCond = 0, BEQ = 0, zero = 0;
  logic [1:0] PCSrc = 0;
  logic [31:0] imem_rdata = 0, alu_result = 0, alu_out = 0;
  logic imem_req, ir_valid, fetch_err;
  logic [31:0] imem_addr, pc, ir;
  logic [5:0] OPcode;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm16;
  int checks = 0, errors = 0;
  logic [31:0] last_ir = 0;
  typedef struct {logic [31:0] pc; logic [31:0] ir;} exp_t;
  logic [31:0] req_q[$];
  exp_t exec_q[$];
  logic prev_req = 0, prev_v = 0;

  fetch_pc_unit dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_done(instr_done), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BEQ(BEQ),
    .PCSrc(PCSrc), .alu_result(alu_result), .alu_out(alu_out), .zero(zero),
    .pc(pc), .ir(ir), .OPcode(OPcode), .rs(rs), .rt(rt), .rd(rd), .imm16(imm16),
    .ir_valid(ir_valid), .fetch_err(fetch_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every fetch start and every EXEC entry consumes one expectation
  always @(negedge clock) begin
    exp_t e;
    if (imem_req && !prev_req) begin
      if (req_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL req_unexpected: got addr %h expected no request", imem_addr);
      end else chk("req_addr", imem_addr, req_q.pop_front());
    end
    if (ir_valid && !prev_v) begin
      if (exec_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL exec_unexpected: got ir %h expected no instruction", ir);
      end else begin
        e = exec_q.pop_front();
        chk("exec_pc", pc, e.pc);
        chk("exec_ir", ir, e.ir);
      end
    end
    prev_req = imem_req;
    prev_v = ir_valid;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_req();
    int n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (imem_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_req: got imem_req %b expected 1 within 20 cycles", imem_req);
    end
  endtask

  // stray PCWrite during the fetch must not move the PC
  task automatic fetch(input logic [31:0] a, input logic [31:0] d, input int waits, input bit drop_run);
    exp_t e;
    e.pc = a;
    e.ir = d;
    req_q.push_back(a);
    exec_q.push_back(e);
    wait_req();
    PCWrite = 1; PCSrc = 2'd0; alu_result = 32'hdead_beef;
    if (drop_run) run = 0;
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("wait_req_high", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, a);
      chk("wait_ir", ir, last_ir);
      chk("wait_pc", pc, a);
    end
    imem_ack = 1; imem_rdata = d;
    tick();
    imem_ack = 0; imem_rdata = 32'hffff_ffff; PCWrite = 0; run = 1;
    last_ir = d;
    chk("exec_valid", {31'd0, ir_valid}, 32'd1);
  endtask

  task automatic retire(input bit pcw, input bit pcwc, input bit beq_v, input bit zero_v,
                        input logic [1:0] src, input logic [31:0] ar, input logic [31:0] ao,
                        input bit run_v, input logic [31:0] exp_pc);
    PCWrite = pcw; PCWriteCond = pcwc; BEQ = beq_v; zero = zero_v;
    PCSrc = src; alu_result = ar; alu_out = ao; run = run_v; instr_done = 1;
    tick();
    instr_done = 0; PCWrite = 0; PCWriteCond = 0;
    chk("retire_pc", pc, exp_pc);
    chk("retire_valid", {31'd0, ir_valid}, 32'd0);
    chk("retire_req", {31'd0, imem_req}, {31'd0, run_v});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1);
  end

  initial begin
    tick(); tick();
    chk("rst_pc", pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_ir", ir, 32'd0);
    @(negedge clock);
    reset = 0;
    fetch(32'd0, 32'h0441_0005, 0, 0);
    chk("opcode", {26'd0, OPcode}, 32'd1);
    chk("rs", {27'd0, rs}, 32'd2);
    chk("rt", {27'd0, rt}, 32'd1);
    chk("rd", {27'd0, rd}, 32'd0);
    chk("imm16", {16'd0, imm16}, 32'd5);
    retire(1, 0, 0, 0, 2'd0, 32'd5, 32'd0, 1, 32'd5);
    fetch(32'd5, 32'h8c22_0004, 3, 1);
    retire(0, 1, 0, 1, 2'd1, 32'd6, 32'd40, 1, 32'd5);
    fetch(32'd5, 32'h8422_ffff, 0, 0);
    retire(0, 1, 0, 0, 2'd1, 32'd6, 32'd40, 1, 32'd40);
    fetch(32'd40, 32'h8000_0001, 1, 0);
    retire(0, 1, 1, 1, 2'd1, 32'd41, 32'h0400_0010, 1, 32'h0400_0010);
    fetch(32'h0400_0010, 32'h0400_0123, 0, 0);
    retire(1, 0, 0, 0, 2'd2, 32'd0, 32'd0, 1, 32'h0400_0123);
    fetch(32'h0400_0123, 32'h0000_0000, 2, 0);
    retire(1, 0, 0, 0, 2'd3, 32'd7, 32'd9, 0, 32'h0400_0123);
    tick(); tick();
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    chk("idle_valid", {31'd0, ir_valid}, 32'd0);
    run = 1;
    req_q.push_back(32'h0400_0123);
    wait_req();
    tick();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #2 reset = 1;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'd0);
    @(negedge clock);
    reset = 0; imem_ack = 1; imem_rdata = 32'hffff_ffff;
    tick();
    imem_ack = 0;
    last_ir = 0;
    chk("late_ack_ir", ir, 32'd0);
    chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
    fetch(32'd0, 32'h0000_2820, 1, 0);
    retire(0, 0, 0, 0, 2'd0, 32'd1, 32'd2, 0, 32'd0);
`ifdef FETCH_TIMEOUT_EN
    begin
      int n = 0;
      run = 1;
      req_q.push_back(32'd0);
      wait_req();
      while (imem_req && n < 400) begin
        tick();
        n++;
      end
      chk("timeout_cycles", n, 32'd255);
      chk("timeout_err", {31'd0, fetch_err}, 32'd1);
      tick(); tick(); tick();
      chk("timeout_locked", {31'd0, imem_req}, 32'd0);
      run = 0;
    end
`else
    chk("no_timeout_err", {31'd0, fetch_err}, 32'd0);
`endif
    tick(); tick();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("exec_q_empty", exec_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
